// File: rtl/button_press_decoder.sv
// Classifies debounced presses as single or double and steps a wrapping mode index; the double-press window exists only with BUTTON_DOUBLE_PRESS_EN.
// Latency: double_press 1 cycle after the second press, single_press WINDOW_CYCLES+1 cycles after the press (1 cycle when the macro is undefined).
// No backpressure: pb_down is a fire-and-forget pulse, every output is a registered one-cycle pulse or level.
module button_press_decoder #(
  parameter int WINDOW_CYCLES = 25_000_000,
  parameter int NUM_MODES     = 4,
  parameter int MODE_W        = 2,
  parameter int RESET_MODE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pb_down,
  output logic              single_press,
  output logic              double_press,
  output logic [MODE_W-1:0] mode,
  output logic              mode_changed
);

  if (WINDOW_CYCLES < 2) begin : g_bad_window
    $error("button_press_decoder: WINDOW_CYCLES must be >= 2");
  end
  if (NUM_MODES < 2 || NUM_MODES > (2 ** MODE_W)) begin : g_bad_modes
    $error("button_press_decoder: NUM_MODES must be in 2..2**MODE_W");
  end
  if (RESET_MODE < 0 || RESET_MODE >= NUM_MODES) begin : g_bad_reset_mode
    $error("button_press_decoder: RESET_MODE must be < NUM_MODES");
  end

  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RESET = MODE_W'(RESET_MODE);

  logic              single_q, single_d;
  logic              double_d;
  logic              mode_changed_q, mode_changed_d;
  logic [MODE_W-1:0] mode_q, mode_d;

`ifdef BUTTON_DOUBLE_PRESS_EN
  localparam int            TW        = $clog2(WINDOW_CYCLES);
  localparam logic [TW-1:0] TIMER_END = TW'(WINDOW_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          double_q;

  // A second press on the final window cycle wins over the timeout.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    single_d = 1'b0;
    double_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pb_down) begin
          state_d = WAIT;
          timer_d = '0;
        end
      end
      WAIT: begin
        if (pb_down) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (timer_q == TIMER_END) begin
          state_d  = IDLE;
          single_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      double_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      double_q <= double_d;
    end
  end

  assign double_press = double_q;
`else
  always_comb begin
    single_d = pb_down;
    double_d = 1'b0;
  end

  assign double_press = 1'b0;
`endif

  always_comb begin
    mode_d         = mode_q;
    mode_changed_d = single_d | double_d;
    if (single_d) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
    end else if (double_d) begin
      mode_d = (mode_q == '0) ? MODE_LAST : mode_q - MODE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_q       <= 1'b0;
      mode_changed_q <= 1'b0;
      mode_q         <= MODE_RESET;
    end else begin
      single_q       <= single_d;
      mode_changed_q <= mode_changed_d;
      mode_q         <= mode_d;
    end
  end

  assign single_press = single_q;
  assign mode_changed = mode_changed_q;
  assign mode         = mode_q;

  a_pulses_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
    !(single_press && double_press));
  a_mode_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    int'(mode) < NUM_MODES);

endmodule

// File: tb/tb_button_press_decoder.sv
// Random and directed presses checked cycle by cycle against a window model kept in absolute cycle numbers.
module tb_button_press_decoder;
  localparam int W    = 8;
  localparam int NM   = 4;
  localparam int MW   = 2;
  localparam int RMODE = 0;

  logic          clk;
  logic          rst_n;
  logic          pb_down;
  logic          single_press;
  logic          double_press;
  logic [MW-1:0] mode;
  logic          mode_changed;

  button_press_decoder #(
    .WINDOW_CYCLES(W),
    .NUM_MODES    (NM),
    .MODE_W       (MW),
    .RESET_MODE   (RMODE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_down     (pb_down),
    .single_press(single_press),
    .double_press(double_press),
    .mode        (mode),
    .mode_changed(mode_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference state: expected outputs after the next active edge.
  int e_single = 0;
  int e_double = 0;
  int e_mc     = 0;
  int e_mode   = RMODE;
`ifdef BUTTON_DOUBLE_PRESS_EN
  bit win_open = 1'b0;
  int win_cyc  = 0;
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
  endtask

  task automatic model_step(input bit pb, input bit rst_v);
    if (!rst_v) begin
      e_single = 0;
      e_double = 0;
      e_mc     = 0;
      e_mode   = RMODE;
`ifdef BUTTON_DOUBLE_PRESS_EN
      win_open = 1'b0;
`endif
      return;
    end
    e_single = 0;
    e_double = 0;
`ifdef BUTTON_DOUBLE_PRESS_EN
    // Window covers the W cycles after the opening press.
    if (win_open) begin
      if (pb) begin
        e_double = 1;
        win_open = 1'b0;
      end else if (cyc - win_cyc == W) begin
        e_single = 1;
        win_open = 1'b0;
      end
    end else if (pb) begin
      win_open = 1'b1;
      win_cyc  = cyc;
    end
`else
    e_single = pb ? 1 : 0;
`endif
    e_mc = e_single | e_double;
    if (e_single != 0) e_mode = (e_mode + 1) % NM;
    if (e_double != 0) e_mode = (e_mode + NM - 1) % NM;
  endtask

  task automatic check_all();
    chk("single_press", int'(single_press), e_single);
    chk("double_press", int'(double_press), e_double);
    chk("mode_changed", int'(mode_changed), e_mc);
    chk("mode",         int'(mode),         e_mode);
  endtask

  // Called at a negedge: drive, advance the model, then check after the edge.
  task automatic step(input bit pb, input bit rst_v);
    rst_n   = rst_v;
    pb_down = pb;
    model_step(pb, rst_v);
    cyc++;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic press();
    step(1'b1, 1'b1);
  endtask

  initial begin
    rst_n   = 1'b0;
    pb_down = 1'b0;
    @(negedge clk);
    check_all();
    chk("reset_mode_const", int'(mode), RMODE);

    // Reset held with a press inside it, then released.
    step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    idle(4);
    chk("no_pulse_after_release", int'(single_press | double_press | mode_changed), 0);

    press(); idle(12);                          // isolated single
    press(); idle(3); press(); idle(12);        // double, gap 4
    press(); idle(W - 1); press(); idle(12);    // second press on last window cycle
    press(); idle(W);     press(); idle(14);    // second press coincident with single
    press(); press(); idle(12);                 // back-to-back pulses
    for (int k = 0; k < 4; k++) begin
      press(); idle(W + 3);
    end
    press(); idle(3); step(1'b0, 1'b0); idle(16);  // reset mid-window
    chk("mode_after_mid_reset", int'(mode), RMODE);

    for (int i = 0; i < 3000; i++) begin
      bit pb;
      bit rv;
      pb = ($urandom_range(0, 5) == 0);
      rv = ($urandom_range(0, 399) != 0);
      step(pb, rv);
    end
    idle(W + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
